// File: rtl/aes_spi_slave_port_if.sv
// SPI bus between a shared-clock SPI master and one AES slave port.
// The master drives select and data in; the slave drives data out.
interface aes_spi_slave_port_if;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output cs_n, output mosi, input miso);
  modport slave  (input cs_n, input mosi, output miso);
endinterface

// File: rtl/aes_spi_slave_port.sv
// SPI slave front-end for an AES core: receives one frame, releases the core,
// captures its result and serialises it back LSB first on the next select frame.
module aes_spi_slave_port #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  aes_spi_slave_port_if.slave spi,
  output logic [WIDTH-1:0]   rx_data,
  output logic               core_reset,
  input  logic               core_done,
  input  logic [WIDTH-1:0]   core_result,
  output logic               result_ready,
  output logic               frame_err
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  typedef enum logic [2:0] {IDLE, RX, RUN, READY, TX} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   rx_data_reg;
  logic [WIDTH-1:0]   tx_shift_reg;
  logic [WIDTH-1:0]   tx_saved_reg;
  logic               core_reset_reg;
  logic               result_ready_reg;
  logic               frame_err_reg;

  logic               sel;
  logic               rx_wr;
  logic [CNT_W-1:0]   wr_idx;
  logic               cnt_full;

  assign sel      = ~spi.cs_n;
  assign cnt_full = (cnt_reg >= WIDTH_C);
  // A new frame always starts at bit 0, whatever the counter holds from before.
  assign wr_idx   = (state_reg == IDLE) ? '0 : cnt_reg;
  assign rx_wr    = sel && ((state_reg == IDLE) || (state_reg == RX && !cnt_full));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sel)       state_next = RX;
      RX:      if (!sel)      state_next = (cnt_reg == WIDTH_C) ? RUN : IDLE;
      RUN:     if (core_done) state_next = READY;
      READY:   if (sel)       state_next = TX;
      TX:      if (!sel)      state_next = cnt_full ? IDLE : READY;
      default:                state_next = IDLE;
    endcase
  end

  // Output logic: miso only carries data while a result frame is selected
  always_comb begin
    spi.miso = 1'b0;
    if ((state_reg == READY || state_reg == TX) && sel)
      spi.miso = tx_shift_reg[0];
  end

  // Receive register, written in place one bit per selected cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rx_data_reg <= '0;
    else if (rx_wr) rx_data_reg[wr_idx[IDX_W-1:0]] <= spi.mosi;
  end

  // Counter, shift register and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg          <= '0;
      tx_shift_reg     <= '0;
      tx_saved_reg     <= '0;
      core_reset_reg   <= 1'b1;
      result_ready_reg <= 1'b0;
      frame_err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (sel) cnt_reg <= CNT_W'(1);
        RX: begin
          if (sel) begin
            if (!cnt_full) cnt_reg <= cnt_reg + 1'b1;
          end else if (cnt_reg == WIDTH_C) begin
            frame_err_reg  <= 1'b0;
            core_reset_reg <= 1'b0;
          end else begin
            frame_err_reg  <= 1'b1;
          end
        end
        RUN: if (core_done) begin
          tx_shift_reg     <= core_result;
          tx_saved_reg     <= core_result;
          result_ready_reg <= 1'b1;
          cnt_reg          <= '0;
        end
        READY, TX: begin
          if (sel) begin
            tx_shift_reg <= tx_shift_reg >> 1;
            // Saturate so an over-long read still counts as complete
            if (!cnt_full) cnt_reg <= cnt_reg + 1'b1;
          end else if (state_reg == TX) begin
            if (cnt_full) begin
              result_ready_reg <= 1'b0;
              core_reset_reg   <= 1'b1;
            end else begin
              cnt_reg      <= '0;
              tx_shift_reg <= tx_saved_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_data      = rx_data_reg;
  assign core_reset   = core_reset_reg;
  assign result_ready = result_ready_reg;
  assign frame_err    = frame_err_reg;

endmodule

// File: tb/tb_aes_spi_slave_port.sv
// Scoreboard bench: a 128-bit and a 256-bit slave port on one clock, driven
// and sampled on the falling edge.
module tb_aes_spi_slave_port;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_spi_slave_port_if spi1();
  aes_spi_slave_port_if spi2();

  logic [127:0] rx_data1, core_result1;
  logic         core_reset1, core_done1, result_ready1, frame_err1;
  logic [255:0] rx_data2, core_result2;
  logic         core_reset2, core_done2, result_ready2, frame_err2;

  aes_spi_slave_port #(.WIDTH(128), .CNT_W(9)) dut1 (
    .clk(clk), .reset(reset), .spi(spi1),
    .rx_data(rx_data1), .core_reset(core_reset1), .core_done(core_done1),
    .core_result(core_result1), .result_ready(result_ready1), .frame_err(frame_err1)
  );

  aes_spi_slave_port #(.WIDTH(256), .CNT_W(9)) dut2 (
    .clk(clk), .reset(reset), .spi(spi2),
    .rx_data(rx_data2), .core_reset(core_reset2), .core_done(core_done2),
    .core_result(core_result2), .result_ready(result_ready2), .frame_err(frame_err2)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [255:0] rx_q[$];
  logic [127:0] tx_q[$];
  logic [255:0] rx_model1 = '0;
  logic [255:0] rx_model2 = '0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %h", tag, got);
    end
  endtask

  // Send nbits of data (bit 0 first) to slave sel, raise cs_n, then check rx_data.
  task automatic send(input bit sel, input logic [255:0] data, input int nbits,
                      output logic core_reset_at_rise);
    logic [255:0] mask, exp;
    mask = (nbits >= 256) ? '1 : ((256'(1) << nbits) - 256'(1));
    if (sel) begin
      exp = (rx_model2 & ~mask) | (data & mask);
      rx_model2 = exp;
    end else begin
      exp = (rx_model1 & ~mask) | (data & mask & {128'b0, {128{1'b1}}});
      rx_model1 = exp;
    end
    rx_q.push_back(exp);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (sel) begin spi2.cs_n = 1'b0; spi2.mosi = data[i]; end
      else     begin spi1.cs_n = 1'b0; spi1.mosi = data[i]; end
    end
    @(negedge clk);
    spi1.cs_n = 1'b1; spi1.mosi = 1'b0;
    spi2.cs_n = 1'b1; spi2.mosi = 1'b0;
    core_reset_at_rise = sel ? core_reset2 : core_reset1;
    @(negedge clk);
    check("rx_data", sel ? rx_data2 : {128'b0, rx_data1}, rx_q.pop_front());
  endtask

  // Clock nbits out of slave 1 and collect miso, then raise cs_n.
  task automatic read1(input int nbits, output logic [127:0] d);
    d = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      spi1.cs_n = 1'b0;
      #1 d[i] = spi1.miso;
    end
    @(negedge clk);
    spi1.cs_n = 1'b1;
    @(negedge clk);
  endtask

  // Present a result to core 1 and check result_ready rises one cycle later.
  task automatic finish_core1(input logic [127:0] res);
    @(negedge clk);
    core_result1 = res;
    core_done1   = 1'b1;
    tx_q.push_back(res);
    check("ready_before", 256'(result_ready1), 256'(0));
    @(negedge clk);
    core_done1 = 1'b0;
    check("ready_after", 256'(result_ready1), 256'(1));
  endtask

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         cr;
  logic [127:0] rd;
  logic [127:0] partial_mask;
  logic [127:0] d2;

  initial begin
    reset = 1'b1;
    spi1.cs_n = 1'b1; spi1.mosi = 1'b0;
    spi2.cs_n = 1'b1; spi2.mosi = 1'b0;
    core_done1 = 1'b0; core_result1 = '0;
    core_done2 = 1'b0; core_result2 = '0;
    repeat (3) @(negedge clk);
    check("rst_miso", 256'(spi1.miso), 256'(0));
    check("rst_rx_data", {128'b0, rx_data1}, 256'(0));
    check("rst_core_reset", 256'(core_reset1), 256'(1));
    check("rst_result_ready", 256'(result_ready1), 256'(0));
    check("rst_frame_err", 256'(frame_err1), 256'(0));
    reset = 1'b0;

    // Full receive frame releases the core one cycle after cs_n rises
    send(1'b0, {128'b0, PT}, 128, cr);
    check("core_reset_at_rise", 256'(cr), 256'(1));
    check("core_reset_released", 256'(core_reset1), 256'(0));
    check("frame_err_full", 256'(frame_err1), 256'(0));

    // Result capture, aborted read, then full read
    finish_core1(CT);
    read1(40, rd);
    partial_mask = (128'(1) << 40) - 128'(1);
    check("partial_read", {128'b0, rd & partial_mask}, {128'b0, tx_q[0] & partial_mask});
    check("ready_after_abort", 256'(result_ready1), 256'(1));
    read1(128, rd);
    check("miso_frame", {128'b0, rd}, {128'b0, tx_q.pop_front()});
    check("ready_cleared", 256'(result_ready1), 256'(0));
    check("core_reset_reheld", 256'(core_reset1), 256'(1));

    // Short frame flags an error and keeps the core in reset
    send(1'b0, {128'b0, ~PT}, 100, cr);
    check("frame_err_short", 256'(frame_err1), 256'(1));
    check("core_reset_short", 256'(core_reset1), 256'(1));
    d2 = 128'hdeadbeef_01234567_89abcdef_fedcba98;
    send(1'b0, {128'b0, d2}, 128, cr);
    check("frame_err_cleared", 256'(frame_err1), 256'(0));
    check("core_reset_after_recover", 256'(core_reset1), 256'(0));
    finish_core1(~CT);
    read1(128, rd);
    check("miso_frame2", {128'b0, rd}, {128'b0, tx_q.pop_front()});

    // Reset in the middle of a receive frame
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      spi1.cs_n = 1'b0; spi1.mosi = PT[i];
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    rx_model1 = '0;
    check("midrst_rx_data", {128'b0, rx_data1}, 256'(0));
    check("midrst_core_reset", 256'(core_reset1), 256'(1));
    check("midrst_result_ready", 256'(result_ready1), 256'(0));
    check("midrst_frame_err", 256'(frame_err1), 256'(0));
    check("midrst_miso", 256'(spi1.miso), 256'(0));
    @(negedge clk);
    spi1.cs_n = 1'b1; spi1.mosi = 1'b0;
    reset = 1'b0;
    send(1'b0, {128'b0, PT}, 128, cr);
    check("core_reset_after_midrst", 256'(core_reset1), 256'(0));

    // 256-bit port: short frame then full key frame
    send(1'b1, KEY, 255, cr);
    check("w256_frame_err_short", 256'(frame_err2), 256'(1));
    check("w256_core_reset_short", 256'(core_reset2), 256'(1));
    send(1'b1, KEY, 256, cr);
    check("w256_frame_err", 256'(frame_err2), 256'(0));
    check("w256_core_reset", 256'(core_reset2), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
